// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: blank code,
// decimal-point bit position and the letter glyph codes.
package seg_pkg;

   localparam logic [4:0] BLANK_CODE = 5'b11111;
   localparam int         DP_BIT     = 4;

   localparam logic [3:0] GLYPH_H = 4'd10;
   localparam logic [3:0] GLYPH_E = 4'd11;
   localparam logic [3:0] GLYPH_L = 4'd12;
   localparam logic [3:0] GLYPH_O = 4'd13;

endpackage

// File: rtl/seven_seg_scan_tick_gen.sv
// Modulo-N counter that advances when en is high and pulses tc on the
// enabled cycle in which it wraps from N-1 back to 0.
module tick_gen #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tc
);

   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_r;

   // Counter advances only on enabled cycles and wraps at N-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (en) begin
         if (cnt_r == LAST) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + W'(1);
         end
      end
   end

   assign tc = en && (cnt_r == LAST);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan driver: shadows a frame of 5-bit digit codes and
// walks the digits at a fixed slot rate, with per-digit enable and blink.
module seven_seg_scan
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 100000,
   parameter int BLINK_DIV  = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [5*NUM_DIGITS-1:0] frame,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [4:0]              seg_code,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    slot_tick
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   logic [5*NUM_DIGITS-1:0] frame_r;
   logic [NUM_DIGITS-1:0]   en_r;
   logic [NUM_DIGITS-1:0]   blink_r;
   logic [IW-1:0]           idx_r;
   logic                    phase_r;

   logic                    slot_tick_s;
   logic                    blink_wrap_s;
   logic                    vis_s;
   logic [4:0]              code_s;
   logic [NUM_DIGITS-1:0]   sel_s;

   tick_gen #(.N(SCAN_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .tc    (slot_tick_s)
   );

   tick_gen #(.N(BLINK_DIV)) u_blink_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (slot_tick_s),
      .tc    (blink_wrap_s)
   );

   assign slot_tick = slot_tick_s;

   // Shadow capture: display logic reads only these, so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_r <= {NUM_DIGITS{BLANK_CODE}};
         en_r    <= '0;
         blink_r <= '0;
      end else if (load) begin
         frame_r <= frame;
         en_r    <= digit_en;
         blink_r <= blink_mask;
      end
   end

   // Digit index and blink phase both step on the slot tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r   <= '0;
         phase_r <= 1'b1;
      end else begin
         if (slot_tick_s) begin
            if (idx_r == LAST_IDX) begin
               idx_r <= '0;
            end else begin
               idx_r <= idx_r + IW'(1);
            end
         end
         if (blink_wrap_s) begin
            phase_r <= ~phase_r;
         end
      end
   end

   // Visibility and select for the current slot, from shadows only.
   always_comb begin
      code_s = frame_r[32'(idx_r) * 32'd5 +: 5];
      vis_s  = en_r[idx_r] && (!blink_r[idx_r] || phase_r);
      sel_s  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;
   end

   // Registered outputs: code and select always change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_code <= BLANK_CODE;
         an       <= '1;
      end else if (vis_s) begin
         seg_code <= code_s;
         an       <= ~sel_s;
      end else begin
         seg_code <= BLANK_CODE;
         an       <= '1;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan with 4 digits,
// a 4-cycle scan slot and a 2-slot blink half-period.
module tb_seven_seg_scan;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int BD = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [19:0]   frame;
   logic          load;
   logic [3:0]    digit_en;
   logic [3:0]    blink_mask;
   logic [4:0]    seg_code;
   logic [3:0]    an;
   logic          slot_tick;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   localparam logic [19:0] F0 = {5'd3, 5'd2, 5'd1, 5'd0};
   localparam logic [19:0] F4 = {5'd3, 5'd2, 5'd1, 5'h15};
   localparam logic [19:0] F5 = {5'h1D, 5'd12, 5'd11, 5'd10};
   localparam logic [19:0] FA = {5'd9, 5'd9, 5'd9, 5'd9};
   localparam logic [19:0] FB = {5'd8, 5'd8, 5'd8, 5'd8};
   localparam logic [19:0] F6 = {5'd7, 5'd6, 5'd5, 5'd4};

   seven_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame      (frame),
      .load       (load),
      .digit_en   (digit_en),
      .blink_mask (blink_mask),
      .seg_code   (seg_code),
      .an         (an),
      .slot_tick  (slot_tick)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // Output after edge cyc reflects the scan state left by edge cyc-1:
   // idx = (m/4)%4 and blink phase flips every 8 edges starting visible.
   task automatic check_scan(input logic [19:0] f, input logic [3:0] en, input logic [3:0] bl);
      int m;
      int d;
      logic ph;
      logic vis;
      logic [3:0] ea;
      logic [4:0] es;
      m   = cyc - 1;
      d   = (m / 4) % 4;
      ph  = ((m / 8) % 2) == 0;
      vis = en[d] && (!bl[d] || ph);
      ea  = vis ? ~(4'b0001 << d) : 4'b1111;
      es  = vis ? f[d*5 +: 5] : 5'h1F;
      check_val("an", 32'(an), 32'(ea));
      check_val("seg", 32'(seg_code), 32'(es));
      check_val("slot_tick", 32'(slot_tick), 32'((cyc % 4) == 3));
   endtask

   initial begin
      frame      = 20'd0;
      load       = 1'b0;
      digit_en   = 4'h0;
      blink_mask = 4'h0;

      @(negedge clk);
      check_val("rst_an", 32'(an), 32'h0000_000F);
      check_val("rst_seg", 32'(seg_code), 32'h0000_001F);
      check_val("rst_tick", 32'(slot_tick), 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      check_val("rel_tick", 32'(slot_tick), 32'h0000_0000);

      // No load: everything blank, slot_tick every 4th cycle.
      repeat (64) begin
         tick();
         check_val("idle_an", 32'(an), 32'h0000_000F);
         check_val("idle_seg", 32'(seg_code), 32'h0000_001F);
         check_val("idle_tick", 32'(slot_tick), 32'((cyc % 4) == 3));
      end

      // Frame {3,2,1,0}, all enabled.
      frame = F0; digit_en = 4'hF; blink_mask = 4'h0; load = 1'b1;
      tick();
      load = 1'b0;
      check_val("load_lat_an", 32'(an), 32'h0000_000F);
      tick();
      check_val("first_an", 32'(an), 32'h0000_000E);
      check_val("first_seg", 32'(seg_code), 32'h0000_0000);
      repeat (18) begin
         tick();
         check_scan(F0, 4'hF, 4'h0);
      end

      // Digit 2 disabled.
      digit_en = 4'b1011; load = 1'b1;
      tick();
      load = 1'b0;
      check_scan(F0, 4'hF, 4'h0);
      repeat (16) begin
         tick();
         check_scan(F0, 4'b1011, 4'h0);
      end

      // Blink on digits 0 and 2, digit 0 carries the decimal point.
      frame = F4; digit_en = 4'hF; blink_mask = 4'b0101; load = 1'b1;
      tick();
      load = 1'b0;
      check_scan(F0, 4'b1011, 4'h0);
      repeat (32) begin
         tick();
         check_scan(F4, 4'hF, 4'b0101);
      end

      // Load coincident with slot_tick: "HELO." frame.
      tick();
      check_val("t5_tick", 32'(slot_tick), 32'h0000_0001);
      frame = F5; digit_en = 4'hF; blink_mask = 4'h0; load = 1'b1;
      tick();
      load = 1'b0;
      check_val("t5_old_an", 32'(an), 32'h0000_000D);
      check_val("t5_old_seg", 32'(seg_code), 32'h0000_0001);
      tick();
      check_val("t5_new_an", 32'(an), 32'h0000_000B);
      check_val("t5_new_seg", 32'(seg_code), 32'h0000_000C);
      repeat (15) begin
         tick();
         check_scan(F5, 4'hF, 4'h0);
      end

      // Load held three cycles: the last frame wins.
      frame = FA; load = 1'b1;
      tick();
      frame = FB;
      tick();
      frame = F6;
      tick();
      load = 1'b0;
      repeat (16) begin
         tick();
         check_scan(F6, 4'hF, 4'h0);
      end

      // Asynchronous reset while digit 2 is on.
      check_val("pre_rst_an", 32'(an), 32'h0000_000B);
      check_val("pre_rst_seg", 32'(seg_code), 32'h0000_0006);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_an", 32'(an), 32'h0000_000F);
      check_val("async_seg", 32'(seg_code), 32'h0000_001F);
      check_val("async_tick", 32'(slot_tick), 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      repeat (16) begin
         tick();
         check_scan(F6, 4'h0, 4'h0);
      end
      load = 1'b1;
      tick();
      load = 1'b0;
      check_val("post_rst_lat", 32'(an), 32'h0000_000F);
      tick();
      check_val("post_rst_an", 32'(an), 32'h0000_000E);
      check_val("post_rst_seg", 32'(seg_code), 32'h0000_0004);
      repeat (8) begin
         tick();
         check_scan(F6, 4'hF, 4'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
